multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Control FSM for the multicycle RV32I core. It sequences instruction fetch, decode, execute, memory access and writeback around the shared instruction decoder, ALU, register file and a single handshaked memory port. It consumes the decoder's opcode, funct3 and funct7 fields plus the branch comparator result. It drives every datapath enable and mux select.

Parameters:
TIMEOUT_CYC, 255, cycles to wait for mem_ready (in FETCH or MEM) before the bus-error trap; counter width is 8 bits, legal range 1..255.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from the decoder, stable from DECODE to end of instruction
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
br_taken  in  1  branch comparator result for the current funct3
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  store when 1; valid only with mem_req
mem_is_fetch  out  1  1 selects the PC as address, 0 selects the ALU result
ir_we  out  1  latch the instruction register
pc_we  out  1  update the PC
pc_sel  out  2  0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1
alu_src_a  out  1  0 rs1, 1 pc
alu_src_b  out  1  0 rs2, 1 imm
alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
reg_we  out  1  register file write enable
wb_sel  out  2  0 alu, 1 mem rdata, 2 pc+4
retire  out  1  one-cycle pulse when an instruction completes
illegal  out  1  sticky flag: unsupported opcode trapped
bus_err  out  1  sticky flag: memory timeout trapped
state_o  out  3  current state for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP.
- Reset, asynchronous: state=FETCH, wait counter=0, class register=0, illegal=0, bus_err=0.
- All outputs are combinational from the state, the class register and mem_ready. Outputs not listed for a state are 0.
- On reset assertion, outputs become the FETCH values: mem_req=1, mem_is_fetch=1, everything else 0.
- FETCH: mem_req=1, mem_is_fetch=1.
  - If mem_ready: ir_we=1, go to DECODE.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYC-1 without mem_ready, go to TRAP and set bus_err.
- DECODE (1 cycle): register the instruction class from opcode.
  - Supported opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BR, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode: go to TRAP and set illegal.
  - Otherwise go to EXEC.
- EXEC:
  - R: alu_op from funct3; funct7[5] selects SUB (funct3=000) or SRA (funct3=101).
  - I: alu_src_b=1; funct7[5] is honoured only for funct3=101.
  - LOAD, STORE: ADD with alu_src_b=1, then go to MEM.
  - LUI: PASSB with alu_src_b=1.
  - AUIPC: ADD with alu_src_a=1, alu_src_b=1.
  - JAL, JALR: compute nothing here, go to WB.
  - BR: alu_op=SUB; pc_we=1 and retire=1; pc_sel=1 if br_taken, else 0; then go to FETCH.
  - Classes other than LOAD, STORE and BR go to WB.
- MEM: mem_req=1, mem_is_fetch=0, mem_we=1 for STORE. Address operands are held the same as in EXEC.
  - On mem_ready, STORE: pc_we=1, pc_sel=0, retire=1, go to FETCH.
  - On mem_ready, LOAD: go to WB.
  - Timeout rule is the same as in FETCH.
- WB: reg_we=1, pc_we=1, retire=1, then go to FETCH.
  - wb_sel: LOAD=1; JAL and JALR=2; others=0.
  - pc_sel: JAL=1; JALR=2; others=0.
  - The ALU operands stay valid for JALR target formation (alu_src_b=1).
- The wait counter clears on every state change.
- TRAP: all outputs 0 except the flags. The FSM stays in TRAP until reset.
- Latency with zero wait states, in cycles: BR=3; R, I, LUI, AUIPC, JAL, JALR, STORE=4; LOAD=5. Each memory wait cycle adds 1.
- rd=x0 masking is the register file's job, not this block's.

Decomposition:
- Shared package core_ctrl_pkg holds the opcode constants, state encodings, alu_op codes, and pc_sel/wb_sel codes.
- One combinational sub-module, alu_op_decode (class, funct3, funct7 -> alu_op), is reused by any future pipelined core.

Test Plan:
- Reset held, then released with mem_ready=1 and an ADD (opcode 0110011, funct3 0, funct7 0). Expect state sequence 0,1,2,4,0; alu_op=0; reg_we and retire in cycle 4.
- Same flow with funct7=0100000. Expect alu_op=1 in EXEC.
- LOAD with mem_ready low for 2 MEM cycles. Expect mem_req=1 and mem_is_fetch=0 for 3 cycles, wb_sel=1 in WB, 7 cycles total.
- BEQ with br_taken=1, then with br_taken=0. Expect pc_we in EXEC with pc_sel 1 then 0, retire after 3 cycles, and no reg_we.
- Opcode 0001111 (FENCE). Expect TRAP and illegal=1 after DECODE, and no further mem_req.
- TIMEOUT_CYC=4 with mem_ready stuck low in FETCH. Expect TRAP and bus_err=1 after 4 cycles.
- Reset asserted mid-MEM. Expect outputs to take FETCH values in the same cycle and both flags to clear.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: states, opcodes,
// instruction classes, ALU operation codes and datapath mux selects.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_I       = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BR      = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } cls_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    case (op)
      OP_R:     c = CLS_R;
      OP_I:     c = CLS_I;
      OP_LOAD:  c = CLS_LOAD;
      OP_STORE: c = CLS_STORE;
      OP_BR:    c = CLS_BR;
      OP_JAL:   c = CLS_JAL;
      OP_JALR:  c = CLS_JALR;
      OP_LUI:   c = CLS_LUI;
      OP_AUIPC: c = CLS_AUIPC;
      default:  c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps instruction class plus funct3/funct7 to an ALU operation code.
// Purely combinational so a pipelined core can reuse it unchanged.
module alu_op_decode
  import core_ctrl_pkg::*;
(
  input  cls_t       cls,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op
);

  // Only bit 5 of funct7 distinguishes RV32I ALU operations.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_op = ALU_ADD;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_op = (cls == CLS_R && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      CLS_LUI: alu_op = ALU_PASSB;
      CLS_BR:  alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state, state_nxt;
  cls_t       cls, cls_dec;
  logic [7:0] wait_cnt;
  logic       illegal_q, bus_err_q;
  logic       set_ill, set_be;
  logic       timeout;
  logic       opnd_a, opnd_b;
  logic [3:0] dec_op;

  alu_op_decode u_alu_op_decode (
    .cls    (cls),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_op)
  );

  assign cls_dec = classify(opcode);
  assign timeout = (wait_cnt == TO_LAST);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state_o = state;

  // Operand selects per class; held from EXEC through WB so the ALU result
  // (or the JALR target) stays valid while it is consumed.
  always_comb begin
    opnd_a = 1'b0;
    opnd_b = 1'b0;
    case (cls)
      CLS_I, CLS_LOAD, CLS_STORE, CLS_LUI, CLS_JALR: opnd_b = 1'b1;
      CLS_AUIPC: begin
        opnd_a = 1'b1;
        opnd_b = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      wait_cnt  <= 8'd0;
      cls       <= CLS_R;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= 8'd0;
      else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (state == ST_DECODE)
        cls <= cls_dec;
      if (set_ill)
        illegal_q <= 1'b1;
      if (set_be)
        bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    set_ill      = 1'b0;
    set_be       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (timeout) begin
          state_nxt = ST_TRAP;
          set_be    = 1'b1;
        end
      end
      ST_DECODE: begin
        if (cls_dec == CLS_ILLEGAL) begin
          state_nxt = ST_TRAP;
          set_ill   = 1'b1;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls != CLS_JAL && cls != CLS_JALR) begin
          alu_src_a = opnd_a;
          alu_src_b = opnd_b;
          alu_op    = dec_op;
        end
        case (cls)
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          CLS_BR: begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            pc_sel    = br_taken ? PC_IMM : PC_PLUS4;
            state_nxt = ST_FETCH;
          end
          default: state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (cls == CLS_STORE);
        alu_src_b = 1'b1;
        alu_op    = dec_op;
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (timeout) begin
          state_nxt = ST_TRAP;
          set_be    = 1'b1;
        end
      end
      ST_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_nxt = ST_FETCH;
        if (cls != CLS_JAL) begin
          alu_src_a = opnd_a;
          alu_src_b = opnd_b;
          alu_op    = dec_op;
        end
        case (cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          default: ;
        endcase
      end
      ST_TRAP: ;
      default: state_nxt = ST_TRAP;
    endcase
  end

endmodule
